// File: rtl/pipelined_parallel_adder.sv
// Pipelined ripple-carry adder: one SLICE-bit slice per stage, carry registered.
// Optional subtract mode compiled in with the PADD_SUB_EN macro.
module pipelined_parallel_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
`ifdef PADD_SUB_EN
    input  logic             Sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out,
    output logic             Overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = WIDTH / SLICE;

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             a_msb;
        logic             b_msb;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_t;

    stage_t           entry;
    stage_t           st_d [STAGES];
    stage_t           st_q [STAGES];
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             en;

`ifdef PADD_SUB_EN
    assign b_eff = Sub ? ~B : B;
    assign c_eff = Sub | Carry_in;
`else
    assign b_eff = B;
    assign c_eff = Carry_in;
`endif

    // Sum slices enter at the top and shift down, so after the last
    // stage slice 0 sits at bit 0 without any per-stage positioning.
    function automatic stage_t add_slice(input stage_t p);
        stage_t           n;
        logic [SLICE:0]   t;
        logic [WIDTH-1:0] s_ext;
        t = {1'b0, p.a_rem[SLICE-1:0]}
          + {1'b0, p.b_rem[SLICE-1:0]}
          + {{SLICE{1'b0}}, p.carry};
        s_ext   = WIDTH'(t[SLICE-1:0]);
        n       = p;
        n.carry = t[SLICE];
        n.sum   = (p.sum >> SLICE) | (s_ext << (WIDTH - SLICE));
        n.a_rem = p.a_rem >> SLICE;
        n.b_rem = p.b_rem >> SLICE;
        return n;
    endfunction

    always_comb begin
        entry       = '0;
        entry.valid = in_valid;
        entry.carry = c_eff;
        entry.a_msb = A[WIDTH-1];
        entry.b_msb = b_eff[WIDTH-1];
        entry.a_rem = A;
        entry.b_rem = b_eff;
    end

    always_comb begin
        st_d[0] = add_slice(entry);
        for (int k = 1; k < STAGES; k++) begin
            st_d[k] = add_slice(st_q[k-1]);
        end
    end

    assign out_valid = st_q[STAGES-1].valid;
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign Sum       = st_q[STAGES-1].sum;
    assign Carry_out = st_q[STAGES-1].carry;
    assign Overflow  = (st_q[STAGES-1].a_msb == st_q[STAGES-1].b_msb)
                    && (st_q[STAGES-1].sum[WIDTH-1] != st_q[STAGES-1].a_msb);

endmodule

// File: doc/pipelined_parallel_adder.md
# pipelined_parallel_adder

Parametrised, pipelined ripple-carry adder for the arithmetic datapath. The WIDTH-bit add is split into SLICE-bit slices, one slice per pipeline stage, with the carry registered between stages. It accepts one operation per cycle under a valid/ready handshake with output backpressure. It extends the combinational 4-bit parallel adder with arbitrary width, pipelining, flow control, a signed-overflow flag and an optional subtract mode.

## Interface
Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of SLICE.
- SLICE, 4: bits added per pipeline stage; must be at least 1.
- STAGES (derived, not overridable): WIDTH/SLICE; this is also the latency in cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Carry_in  in  1  carry into bit 0.
- in_valid  in  1  A, B, Carry_in (and Sub) are valid this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- Sum  out  WIDTH  result.
- Carry_out  out  1  carry out of bit WIDTH-1.
- Overflow  out  1  two's-complement overflow of the result.
- out_valid  out  1  Sum, Carry_out and Overflow are valid.
- out_ready  in  1  downstream accepts the result this cycle.
- Sub  in  1  present only when the subtract mode is compiled in (see Configuration).

## Operation
- Pipeline stage k (k = 0..STAGES-1) adds slice k of A and B plus the carry from stage k-1. Stage 0 uses Carry_in.
- Each stage register holds: the sum slices produced so far, the not-yet-consumed upper slices of A and B, the carry, the sign bits of A and B, and a valid bit.
- Global stall enable: en = !out_valid || out_ready.
  - When en=1, every stage shifts forward one position.
  - When en=0, every stage holds its contents.
  - Bubbles are not collapsed.
- in_ready = en (combinational). An operation is accepted on an edge where in_valid && in_ready.
- If in_valid=0 while en=1, a bubble (valid=0) enters stage 0.
- Result definitions:
  - Sum = (A + B + Carry_in) mod 2^WIDTH.
  - Carry_out = bit WIDTH of the full sum.
  - Overflow = (A[MSB] == B'[MSB]) && (Sum[MSB] != A[MSB]), where B' is the operand actually added.
- Output handshake:
  - A result is held stable while out_valid && !out_ready.
  - It is retired on an edge with out_valid && out_ready.
- Ordering: results leave strictly in acceptance order. No operation is dropped or duplicated.
- Reset values, applied on any edge where rst=1:
  - All stage valid bits, out_valid, Sum, Carry_out and Overflow = 0.
  - in_ready is therefore 1 in the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded; none appear at the output.
- Simultaneous rst and in_valid: reset wins and the input is not accepted.
- Degenerate case SLICE = WIDTH (STAGES = 1): the block is a single registered adder.

## Timing
- Latency: an operation accepted on edge n has out_valid=1 after edge n+STAGES-1. With default parameters, accepted on edge 0 means valid after edge 3.
- Throughput: one operation per cycle while out_ready=1.
- Stall propagation:
  - out_ready=0 with out_valid=1 drops in_ready in the same cycle.
  - in_ready returns the cycle out_ready rises.
- Combinational paths: out_ready to in_ready only. The critical path is a single SLICE-bit add.

## Configuration
- Macro: PADD_SUB_EN.
- When defined:
  - The Sub input is present and travels with its operation.
  - Sub=1 computes A - B as A + ~B + 1; Carry_in is ignored.
  - Carry_out=1 means no borrow. Overflow uses B' = ~B.
  - Sub=0 behaves as plain add.
- When undefined: there is no Sub port, and the block is add-only.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
- Reset: hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, Sum=0, Carry_out=0, Overflow=0, in_ready=1, and no output ever appears from those inputs.
- Full carry ripple: A=16'hFFFF, B=16'h0001, Carry_in=0 accepted on edge 0 → after edge 3: Sum=16'h0000, Carry_out=1, Overflow=0.
- Signed overflow: A=16'h7FFF, B=16'h0001, Carry_in=0 → Sum=16'h8000, Carry_out=0, Overflow=1. Also A=16'h8000, B=16'h8000, Carry_in=1 → Sum=16'h0001, Carry_out=1, Overflow=1.
- Backpressure: send 8 back-to-back random operations, deassert out_ready for 5 cycles mid-stream → in_ready=0 during the stall, held output stable, all 8 results match the golden model and arrive in order.
- Mid-flight reset: accept 3 operations, assert rst on the next edge → no out_valid for those 3; a new operation afterwards emerges with 4-cycle latency.
- With PADD_SUB_EN: A=16'h0005, B=16'h0007, Sub=1 → Sum=16'hFFFE, Carry_out=0, Overflow=0. A=16'h8000, B=16'h0001, Sub=1 → Sum=16'h7FFF, Carry_out=1, Overflow=1.
